// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//
// Per-bit synchronizer and debouncer for the board slide switches.
//
// Each raw switch bit passes through a two-flop synchronizer into the i_clk
// domain. A new level on a bit is accepted into o_sw only after the
// synchronized value has disagreed with o_sw for DEBOUNCE_CYCLES consecutive
// cycles. Every bit has its own independent two-state FSM and stability
// counter.
//
// Parameters
//   NB_SW           number of switch bits
//   NB_CNT          width of each per-bit stability counter
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a new level
//                   (2 .. 2**NB_CNT)
//   RESET_VAL       reset value of the synchronizer stages and o_sw
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_sw       raw asynchronous switch levels
//   o_sw       debounced switch levels (registered)
//   o_change   one-cycle pulse when any bit of o_sw changes
//   o_sw_rise  one-cycle per-bit pulse on a 0->1 change of o_sw
//   o_sw_fall  one-cycle per-bit pulse on a 1->0 change of o_sw
//
// Build option
//   SW_DEBOUNCE_EDGE_EN  when defined, the per-bit rise/fall pulse registers
//                        are built; otherwise o_sw_rise/o_sw_fall are tied
//                        to 0. o_sw, o_change and latency are unaffected.
// ---------------------------------------------------------------------------
module sw_debounce #(
    parameter int               NB_SW           = 4,
    parameter int               NB_CNT          = 20,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter logic [NB_SW-1:0] RESET_VAL       = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NB_SW-1:0] i_sw,
    output logic [NB_SW-1:0] o_sw,
    output logic             o_change,
    output logic [NB_SW-1:0] o_sw_rise,
    output logic [NB_SW-1:0] o_sw_fall
);

    // Counter value on the cycle where the DEBOUNCE_CYCLES-th consecutive
    // mismatch is seen; acceptance happens instead of counting past it.
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    logic [NB_SW-1:0] r_sync1;
    logic [NB_SW-1:0] r_sync2;
    logic [NB_SW-1:0] r_sw;
    logic             r_change;
    wire  [NB_SW-1:0] w_accept;

    // Two-flop synchronizer; both stages start at the reset level so a
    // switch already sitting at RESET_VAL produces no activity after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
        end
    end

    // One independent debounce FSM plus counter per switch bit.
    for (genvar k = 0; k < NB_SW; k++) begin : g_bit
        state_t            r_state;
        state_t            w_state_next;
        logic [NB_CNT-1:0] r_cnt;
        logic [NB_CNT-1:0] w_cnt_next;
        logic              w_acc;

        // State and counter registers for this bit.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_next;
                r_cnt   <= w_cnt_next;
            end
        end

        // Next-state logic. Any cycle where the synchronized level agrees
        // with o_sw again throws away the partial count, so only an
        // unbroken run of mismatches can reach acceptance.
        always_comb begin
            w_state_next = r_state;
            w_cnt_next   = r_cnt;
            w_acc        = 1'b0;
            case (r_state)
                ST_STABLE: begin
                    if (r_sync2[k] != r_sw[k]) begin
                        w_state_next = ST_CHECK;
                        w_cnt_next   = NB_CNT'(1);
                    end
                end
                ST_CHECK: begin
                    if (r_sync2[k] == r_sw[k]) begin
                        w_state_next = ST_STABLE;
                        w_cnt_next   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_acc        = 1'b1;
                        w_state_next = ST_STABLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = r_cnt + NB_CNT'(1);
                    end
                end
                default: begin
                    w_state_next = ST_STABLE;
                    w_cnt_next   = '0;
                end
            endcase
        end

        assign w_accept[k] = w_acc;
    end

    // Accepted levels and the aggregate change strobe. An accepted bit
    // always differs from its current o_sw value, so toggling it loads the
    // synchronized level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sw     <= RESET_VAL;
            r_change <= 1'b0;
        end else begin
            r_sw     <= r_sw ^ w_accept;
            r_change <= |w_accept;
        end
    end

    assign o_sw     = r_sw;
    assign o_change = r_change;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [NB_SW-1:0] r_rise;
    logic [NB_SW-1:0] r_fall;

    // Edge pulses are registered alongside o_sw so they coincide with the
    // level update; the direction is the newly accepted synchronized level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_accept & r_sync2;
            r_fall <= w_accept & ~r_sync2;
        end
    end

    assign o_sw_rise = r_rise;
    assign o_sw_fall = r_fall;
`else
    assign o_sw_rise = '0;
    assign o_sw_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
//
// Self-checking bench for sw_debounce with DEBOUNCE_CYCLES = 4 and
// RESET_VAL = 0. A reference model keeps a short history of the raw switch
// samples and accepts a bit once the level it sees after the two
// synchronizer stages has disagreed with the debounced value for
// DEBOUNCE_CYCLES samples in a row. Outputs are compared on every falling
// edge; directed scenarios add latency and pulse checks.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

    localparam int               NB_SW  = 4;
    localparam int               NB_CNT = 8;
    localparam int               DC     = 4;
    localparam logic [NB_SW-1:0] RV     = '0;
    localparam int               LAT    = DC + 1;

`ifdef SW_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NB_SW-1:0] i_sw = '0;
    logic [NB_SW-1:0] o_sw;
    logic             o_change;
    logic [NB_SW-1:0] o_sw_rise;
    logic [NB_SW-1:0] o_sw_fall;

    int numChecks   = 0;
    int numFailures = 0;

    sw_debounce #(
        .NB_SW           (NB_SW),
        .NB_CNT          (NB_CNT),
        .DEBOUNCE_CYCLES (DC),
        .RESET_VAL       (RV)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sw      (i_sw),
        .o_sw      (o_sw),
        .o_change  (o_change),
        .o_sw_rise (o_sw_rise),
        .o_sw_fall (o_sw_fall)
    );

    always #5 clk = ~clk;

    // Reference model: history of raw samples, one per rising edge.
    logic [NB_SW-1:0] sampleHist[$];
    logic [NB_SW-1:0] mSw;
    logic [NB_SW-1:0] mRise;
    logic [NB_SW-1:0] mFall;
    logic             mChange;

    // The synchronized level seen at edge n is the raw sample from edge
    // n-2, so the window is the DC samples ending two edges back.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sampleHist.delete();
            for (int i = 0; i < DC + 2; i++) sampleHist.push_back(RV);
            mSw     <= RV;
            mRise   <= '0;
            mFall   <= '0;
            mChange <= 1'b0;
        end else begin
            logic [NB_SW-1:0] acc;
            logic             held;
            acc = '0;
            for (int k = 0; k < NB_SW; k++) begin
                held = 1'b1;
                for (int j = 1; j <= DC; j++)
                    if (sampleHist[sampleHist.size() - 1 - j][k] == mSw[k])
                        held = 1'b0;
                acc[k] = held;
            end
            mSw     <= mSw ^ acc;
            mRise   <= acc & ~mSw;
            mFall   <= acc & mSw;
            mChange <= |acc;
            sampleHist.push_back(i_sw);
            void'(sampleHist.pop_front());
        end
    end

    function automatic logic [NB_SW-1:0] edgeExp(input logic [NB_SW-1:0] v);
        return EDGE_EN ? v : '0;
    endfunction

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFailures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output to the model.
    task automatic tick();
        @(negedge clk);
        checkOutput("sw",     32'(o_sw),      32'(mSw));
        checkOutput("change", 32'(o_change),  32'(mChange));
        checkOutput("rise",   32'(o_sw_rise), 32'(edgeExp(mRise)));
        checkOutput("fall",   32'(o_sw_fall), 32'(edgeExp(mFall)));
    endtask

    task automatic applyStimulus(input logic [NB_SW-1:0] value, input int cycles);
        i_sw = value;
        repeat (cycles) tick();
    endtask

    // Counts falling edges until bit bitIdx reaches target; the first
    // falling edge follows the sampling edge E0, hence the minus one.
    task automatic measureLatency(input int bitIdx, input logic target,
                                  input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (o_sw[bitIdx] !== target && n < 30);
        checkOutput(tag, 32'(n - 1), 32'(LAT));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NB_SW-1:0] nextSw;

        // Reset state.
        applyStimulus(4'b0000, 3);
        checkOutput("rstSw",     32'(o_sw),      32'h0);
        checkOutput("rstChange", 32'(o_change),  32'h0);
        checkOutput("rstRise",   32'(o_sw_rise), 32'h0);
        checkOutput("rstFall",   32'(o_sw_fall), 32'h0);

        // Idle after release.
        rst = 1'b0;
        applyStimulus(4'b0000, 20);
        checkOutput("idleSw", 32'(o_sw), 32'h0);

        // Single step on bit 0.
        i_sw = 4'b0001;
        measureLatency(0, 1'b1, "riseLat0");
        checkOutput("riseStep0", 32'(o_sw_rise), 32'(edgeExp(4'b0001)));
        checkOutput("chgStep0",  32'(o_change),  32'h1);
        tick();
        checkOutput("chgOnce0",  32'(o_change),  32'h0);

        // Bouncing bit 1: bring it to 1, bounce, then settle at 0.
        i_sw = 4'b0011;
        measureLatency(1, 1'b1, "riseLat1");
        applyStimulus(4'b0011, 3);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0001, 2);
            applyStimulus(4'b0011, 2);
        end
        checkOutput("bounceHold", 32'(o_sw[1]), 32'h1);
        i_sw = 4'b0001;
        measureLatency(1, 1'b0, "fallLat1");
        checkOutput("fallStep1", 32'(o_sw_fall), 32'(edgeExp(4'b0010)));

        // Two bits stepping on the same edge.
        applyStimulus(4'b0001, 3);
        i_sw = 4'b1101;
        measureLatency(2, 1'b1, "riseLat32");
        checkOutput("sw32",     32'(o_sw),      32'h0000000d);
        checkOutput("rise32",   32'(o_sw_rise), 32'(edgeExp(4'b1100)));
        checkOutput("change32", 32'(o_change),  32'h1);
        tick();
        checkOutput("chgOnce32", 32'(o_change), 32'h0);

        // Reset in the middle of a count on bit 0.
        i_sw = 4'b1100;
        measureLatency(0, 1'b0, "fallLat0");
        applyStimulus(4'b1100, 2);
        applyStimulus(4'b1101, 3);
        rst = 1'b1;
        #1;
        checkOutput("midRstSw",  32'(o_sw),     32'h0);
        checkOutput("midRstChg", 32'(o_change), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        measureLatency(0, 1'b1, "postRstLat");
        checkOutput("postRstSw", 32'(o_sw), 32'h0000000d);

        // Randomized activity with one reset pulse part way through.
        for (int c = 0; c < 400; c++) begin
            nextSw = i_sw;
            for (int k = 0; k < NB_SW; k++)
                if ($urandom_range(5) == 0) nextSw[k] = ~nextSw[k];
            if (c == 200) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            applyStimulus(nextSw, 1);
        end
        applyStimulus(i_sw, 10);

        $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
        $finish;
    end

endmodule
